uart_word_tx: RTL and testbench

UART_WORD_TX -- requirements
Module: uart_word_tx

---
 rtl/uart_word_tx.sv | 158 +++++++++++++++
 tb/tb_uart_word_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// uart_word_tx: queues multi-byte words in a small FIFO and sends them as 8N1 UART frames.
//   Parameters: CLKS_PER_BIT (cycles per serial bit, >=2), WORD_BYTES (bytes per word, >=1),
//               DEPTH (FIFO words, power of 2, >=2).
//   Ports: clock   - rising-edge clock
//          reset   - synchronous active-high reset; aborts any frame and empties the FIFO
//          word_in - word to queue, sent most-significant byte first, each byte LSB first
//          word_we - write strobe for word_in
//          full    - FIFO holds DEPTH words
//          busy    - a frame is on the line or the FIFO is non-empty
//          txd     - registered serial output, idle high
//          error   - sticky flag: a write was dropped because the FIFO was full
//   Macro UART_TX_PARITY_EN adds an even-parity bit after the data bits of each byte.
module uart_word_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int WORD_BYTES   = 4,
    parameter int DEPTH        = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [8*WORD_BYTES-1:0] word_in,
    input  logic                    word_we,
    output logic                    full,
    output logic                    busy,
    output logic                    txd,
    output logic                    error
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int YW = WORD_BYTES > 1 ? $clog2(WORD_BYTES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t                  state, state_n;
    logic [BW-1:0]           baud_cnt, baud_n;
    logic [2:0]              bit_cnt, bit_n;
    logic [YW-1:0]           byte_cnt, byte_n;
    logic                    txd_n;
    logic                    pop, shift, push, drop, tick;
    logic [8*WORD_BYTES-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [CW-1:0]           count;
    logic [8*WORD_BYTES-1:0] word_r;
    logic [7:0]              cur_byte;

    assign full     = count == CW'(DEPTH);
    assign busy     = state != IDLE || count != '0;
    // A write into a full FIFO still lands if the FSM frees a slot on the same edge.
    assign push     = word_we && (!full || pop);
    assign drop     = word_we && full && !pop;
    assign tick     = baud_cnt == BW'(CLKS_PER_BIT - 1);
    // The word being sent shifts left one byte per frame, so the current byte is always on top.
    assign cur_byte = word_r[8*WORD_BYTES-1 -: 8];

    always_comb begin
        state_n = state;
        baud_n  = tick ? '0 : baud_cnt + BW'(1);
        bit_n   = bit_cnt;
        byte_n  = byte_cnt;
        txd_n   = txd;
        pop     = 1'b0;
        shift   = 1'b0;
        case (state)
            IDLE: begin
                baud_n = '0;
                if (count != '0) begin
                    pop     = 1'b1;
                    state_n = START;
                    byte_n  = '0;
                    txd_n   = 1'b0;
                end
            end
            START: if (tick) begin
                state_n = DATA;
                bit_n   = '0;
                txd_n   = cur_byte[0];
            end
            DATA: if (tick) begin
                if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_n = PARITY;
                    txd_n   = ^cur_byte;
`else
                    state_n = STOP;
                    txd_n   = 1'b1;
`endif
                end else begin
                    bit_n = bit_cnt + 3'd1;
                    txd_n = cur_byte[bit_n];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) begin
                state_n = STOP;
                txd_n   = 1'b1;
            end
`endif
            STOP: if (tick) begin
                if (byte_cnt != YW'(WORD_BYTES - 1)) begin
                    byte_n  = byte_cnt + YW'(1);
                    shift   = 1'b1;
                    state_n = START;
                    txd_n   = 1'b0;
                end else if (count != '0) begin
                    // Back-to-back words: the next start bit follows the stop bit directly.
                    pop     = 1'b1;
                    byte_n  = '0;
                    state_n = START;
                    txd_n   = 1'b0;
                end else begin
                    byte_n  = '0;
                    state_n = IDLE;
                    txd_n   = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            txd      <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            error    <= 1'b0;
            word_r   <= '0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            byte_cnt <= byte_n;
            txd      <= txd_n;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count    <= count + CW'(push) - CW'(pop);
            if (drop) error <= 1'b1;
            if (pop) word_r <= mem[rd_ptr];
            else if (shift) word_r <= word_r << 8;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) mem[wr_ptr] <= word_in;
    end
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: self-checking bench for uart_word_tx with a byte scoreboard and a serial decoder.
module tb_uart_word_tx;
    localparam int CPB   = 4;
    localparam int CPB2  = 2;
    localparam int WB    = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int WC  = WB * NB * CPB;
    localparam int WC2 = WB * NB * CPB2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] word_in = '0;
    logic [31:0] word_in2 = '0;
    logic        word_we = 1'b0;
    logic        word_we2 = 1'b0;
    logic        full, busy, txd, error;
    logic        full2, busy2, txd2, error2;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q [$];

    uart_word_tx #(.CLKS_PER_BIT(CPB), .WORD_BYTES(WB), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .word_in(word_in), .word_we(word_we),
        .full(full), .busy(busy), .txd(txd), .error(error)
    );

    uart_word_tx #(.CLKS_PER_BIT(CPB2), .WORD_BYTES(WB), .DEPTH(DEPTH)) dut2 (
        .clock(clock), .reset(reset), .word_in(word_in2), .word_we(word_we2),
        .full(full2), .busy(busy2), .txd(txd2), .error(error2)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic void push_word(input logic [31:0] w);
        for (int i = WB - 1; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
    endfunction

    // Expected line level t cycles after the start edge of word w.
    function automatic logic exp_bit(input logic [31:0] w, input int t, input int cpb);
        int f, p;
        logic [7:0] b;
        f = t / (NB * cpb);
        p = (t % (NB * cpb)) / cpb;
        b = 8'(w >> (8 * (WB - 1 - f)));
        if (p == 0) return 1'b0;
        if (p <= 8) return b[p-1];
        if (NB == 11 && p == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while (busy && k < bound) begin
            @(negedge clock);
            k++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    // Serial decoder for dut: samples mid-bit, checks framing, gaps and the byte scoreboard.
    initial begin
        int n, prev_start, p;
        bit act, pv;
        logic [7:0] rx;
        n = 0; prev_start = 0; act = 0; pv = 0; rx = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                act = 0;
                pv  = 0;
            end else if (!act) begin
                if (!busy) pv = 0;
                if (txd === 1'b0) begin
                    act = 1;
                    n   = 0;
                    if (pv) chk("frame_gap", cyc - prev_start, NB * CPB);
                    prev_start = cyc;
                    pv = 1;
                end
            end else begin
                n++;
                if (n % CPB == CPB / 2) begin
                    p = n / CPB;
                    if (p == 0) chk("start_bit", txd, 0);
                    else if (p <= 8) rx = {txd, rx[7:1]};
                    else if (p == NB - 1) begin
                        chk("stop_bit", txd, 1);
                        if (exp_q.size() == 0) chk("rx_extra", exp_q.size(), 1);
                        else chk("rx_byte", rx, exp_q.pop_front());
                    end else chk("parity_bit", txd, ^rx);
                end
                if (n == NB * CPB - 1) act = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int a, s, e, k;
        logic [31:0] wb [6];
        logic [31:0] late, x, y;
        wb[0] = 32'hA1B2C3D4; wb[1] = 32'h0F1E2D3C; wb[2] = 32'h80402010;
        wb[3] = 32'hFFFFFFFF; wb[4] = 32'h00000000; wb[5] = 32'hDEADBEEF;
        late = 32'h5AA5C33C;
        x = 32'h3C5A96E1;
        y = 32'h7E01B24D;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_error", error, 0);
        chk("rst_txd2", txd2, 1);
        chk("rst_busy2", busy2, 0);

        // Single word: start bit one edge after the write, then a WC-cycle word.
        @(negedge clock);
        word_in = 32'h12345678; word_we = 1'b1; push_word(word_in);
        @(negedge clock);
        word_we = 1'b0;
        chk("write_edge_txd", txd, 1);
        chk("busy_on_write", busy, 1);
        @(negedge clock);
        chk("start_edge_txd", txd, 0);
        s = cyc;
        k = 0;
        while (busy && k < 2 * WC) begin
            @(negedge clock);
            k++;
        end
        chk("word_cycles", cyc - s, WC);
        chk("idle_txd", txd, 1);

        // Burst of writes: fill, drop one on full, then slip one in on a pop edge.
        @(negedge clock);
        a = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) chk("full_before_4th", full, 0);
            if (i == 5) begin
                chk("full_after_4", full, 1);
                chk("no_error_yet", error, 0);
            end
            word_in = wb[i]; word_we = 1'b1;
            if (i < 5) push_word(wb[i]);
            @(negedge clock);
        end
        word_we = 1'b0;
        chk("error_on_drop", error, 1);
        chk("full_after_drop", full, 1);
        while (cyc < a + WC) @(negedge clock);
        chk("full_before_swap", full, 1);
        word_in = late; word_we = 1'b1; push_word(late);
        @(negedge clock);
        word_we = 1'b0;
        chk("full_after_swap", full, 1);
        chk("error_held", error, 1);
        wait_idle(8 * WC);
        chk("error_sticky", error, 1);

        // Reset 50 cycles into a word aborts it and clears everything.
        @(negedge clock);
        word_in = 32'hCAFEF00D; word_we = 1'b1; push_word(word_in);
        a = cyc + 1;
        @(negedge clock);
        word_we = 1'b0;
        while (cyc < a + 50) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        chk("abort_txd", txd, 1);
        chk("abort_busy", busy, 0);
        chk("abort_full", full, 0);
        chk("abort_error", error, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        word_in = 32'hA5C30F81; word_we = 1'b1; push_word(word_in);
        @(negedge clock);
        word_we = 1'b0;
        wait_idle(2 * WC);

        // Parity corner word.
        @(negedge clock);
        word_in = 32'h000000FF; word_we = 1'b1; push_word(word_in);
        @(negedge clock);
        word_we = 1'b0;
        wait_idle(2 * WC);

        // Fast instance: write on the edge that ends the last stop bit.
        @(negedge clock);
        word_in2 = x; word_we2 = 1'b1;
        a = cyc + 1;
        @(negedge clock);
        word_we2 = 1'b0;
        s = a + 1;
        e = s + WC2;
        while (cyc < e + WC2) begin
            if (cyc == e - 1) begin
                word_in2 = y; word_we2 = 1'b1;
            end else word_we2 = 1'b0;
            @(negedge clock);
            if (cyc >= s && cyc < e) chk("d2_bit_a", txd2, exp_bit(x, cyc - s, CPB2));
            else if (cyc == e) begin
                chk("d2_gap", txd2, 1);
                chk("d2_busy", busy2, 1);
            end else if (cyc > e) chk("d2_bit_b", txd2, exp_bit(y, cyc - e - 1, CPB2));
        end
        word_we2 = 1'b0;
        @(negedge clock);
        chk("d2_idle_busy", busy2, 0);
        chk("d2_idle_txd", txd2, 1);
        chk("d2_error", error2, 0);
        chk("d2_full", full2, 0);

        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
